// File: rtl/pattern_scan_ctrl.sv
// Frame controller that serializes bytes MSB-first into a PAT_W-bit sliding
// window and counts overlapping pattern hits over a software-sized frame.
module pattern_scan_ctrl #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1001,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [7:0]       frame_bytes,
    input  logic             start,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [1:0]        state_q, state_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [7:0]        byte_q, byte_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        frame_len_q, frame_len_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic              match_pulse_q, match_pulse_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

    logic              shift_bit;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    // Window and fill as they will look after this cycle's shift; the hit
    // decision is made on the post-shift view.
    always_comb begin
        shift_bit  = byte_q[bit_idx_q];
        hist_shift = {hist_q[PAT_W-2:0], shift_bit};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        hit        = (hist_shift == pattern_q) && (fill_inc == FILL_FULL);
    end

    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        byte_d        = byte_q;
        bit_idx_d     = bit_idx_q;
        frame_len_d   = frame_len_q;
        byte_cnt_d    = byte_cnt_q;
        match_pulse_d = 1'b0;
        match_cnt_d   = match_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                end
                if (start) begin
                    match_cnt_d = '0;
                    if (frame_bytes != 8'd0) begin
                        hist_d      = '0;
                        fill_d      = '0;
                        frame_len_d = frame_bytes;
                        byte_cnt_d  = 8'd0;
                        state_d     = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    byte_d     = s_data;
                    bit_idx_d  = 3'd7;
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                hist_d    = hist_shift;
                fill_d    = fill_inc;
                bit_idx_d = bit_idx_q - 3'd1;
                if (hit) begin
                    match_pulse_d = 1'b1;
                    if (!(&match_cnt_q)) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end
                if (bit_idx_q == 3'd0) begin
                    state_d = (byte_cnt_q == frame_len_q) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= ST_IDLE;
            pattern_q     <= PAT_RST;
            hist_q        <= '0;
            fill_q        <= '0;
            byte_q        <= 8'd0;
            bit_idx_q     <= 3'd0;
            frame_len_q   <= 8'd0;
            byte_cnt_q    <= 8'd0;
            match_pulse_q <= 1'b0;
            match_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            byte_q        <= byte_d;
            bit_idx_q     <= bit_idx_d;
            frame_len_q   <= frame_len_d;
            byte_cnt_q    <= byte_cnt_d;
            match_pulse_q <= match_pulse_d;
            match_cnt_q   <= match_cnt_d;
        end
    end

    assign s_ready     = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign match_pulse = match_pulse_q;
    assign match_cnt   = match_cnt_q;

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Frame-level controller that sequences a serial bit-pattern detector.
- Accepts bytes over a valid/ready stream and serializes each byte MSB-first into a programmable PAT_W-bit sliding-window matcher.
- Counts overlapping pattern hits across a software-sized frame, then reports completion.
- Sits between a byte source (UART/FIFO) and status logic.

Parameters:
- PAT_W, 4, pattern length in bits (2..8).
- PAT_RST, 4'b1001, pattern value loaded at reset (width PAT_W).
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-high: asserted when 1, sampled on clk rising edge only.
- cfg_we  input  1  pattern write strobe; honoured only in IDLE.
- cfg_pattern  input  PAT_W  new pattern; MSB is the oldest bit.
- frame_bytes  input  8  bytes per frame; sampled when start is accepted.
- start  input  1  begin frame; honoured only in IDLE.
- s_valid  input  1  byte source valid.
- s_data  input  8  byte from source.
- s_ready  output  1  controller can take a byte.
- busy  output  1  high whenever state != IDLE.
- match_pulse  output  1  one-cycle pulse per pattern hit.
- match_cnt  output  CNT_W  hits in current/last frame.
- done  output  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset:
  - State IDLE.
  - pattern = PAT_RST.
  - History and fill count cleared.
  - All outputs 0 (s_ready, busy, match_pulse, match_cnt, done).
  - Reset asserted mid-frame aborts the frame immediately. No done pulse is issued and the partial count is discarded.
- States:
  - IDLE:
    - s_ready=0.
    - cfg_we loads pattern.
    - start with frame_bytes>0: clear match_cnt, history and fill count; latch frame_bytes; go to LOAD.
    - start with frame_bytes==0: clear match_cnt; go to DONE.
    - If cfg_we and start are both high in the same cycle, the pattern write takes effect for that frame.
  - LOAD:
    - s_ready=1 (combinational from state).
    - On s_valid&&s_ready: capture s_data, set bit index to 7, go to SHIFT.
    - Source stalls (s_valid=0) hold LOAD indefinitely.
  - SHIFT:
    - s_ready=0.
    - Each cycle shifts byte[bit_idx] into the history LSB and decrements bit_idx.
    - Fill count increments, saturating at PAT_W.
    - Takes exactly 8 cycles per byte.
    - After bit 0: if bytes consumed == latched frame_bytes, go to DONE; otherwise go to LOAD.
  - DONE:
    - done=1 for exactly one cycle, then IDLE.
- Matching:
  - Hit when the post-shift window (history after including the current bit) equals pattern AND fill count (after the shift) is >= PAT_W.
  - Overlapping hits are counted: bits may be shared between hits.
  - History carries across bytes within a frame. It never carries across frames.
- Timing:
  - match_pulse and the match_cnt increment are registered on the same edge that shifts the bit, so both are visible in the following cycle.
  - Byte accepted at edge E → bits consumed at edges E+1..E+8 → last possible pulse is visible after E+8, coinciding with the DONE or LOAD cycle.
  - DONE follows the last SHIFT cycle, so done is asserted in the same cycle as a hit on the final bit.
  - match_cnt is stable when done=1.
- Counter:
  - match_cnt saturates at all-ones; no wrap.
  - Holds its value in IDLE until the next accepted start.
- Ignored inputs:
  - start while busy is ignored.
  - cfg_we while busy is ignored; the pattern is unchanged.
- Throughput: peak of one byte per 9 cycles (1 LOAD + 8 SHIFT) with s_valid held high.

Test Plan:
- Default pattern 1001, frame_bytes=1, byte 0x99 (10011001) → match_pulse after bits 4 and 8; match_cnt=2; done 10 cycles after the start edge; busy low the cycle after done.
- Overlap: byte 0x49 (01001001) → hits ending at bits 5 and 8 (bit 5 shared); match_cnt=2.
- Cross-byte: frame_bytes=2, bytes 0x01 then 0x20 → single hit at stream bit 11; match_cnt=1.
- No cross-frame carry:
  - frame 0x01, then a new frame 0x20 → match_cnt=0 for both.
  - Backpressure: s_valid held low 5 cycles between bytes → same counts; s_ready high throughout the stall.
- Config and zero-length frames:
  - cfg_we with 4'b1111 while busy → ignored, frame still matches 1001.
  - cfg_we with 4'b1111 in IDLE, then byte 0xFF → match_cnt=5.
  - frame_bytes=0 → done one cycle after start, match_cnt=0, s_ready never high.
- Reset mid-SHIFT:
  - rst_n=1 for one cycle during the 3rd bit → next cycle state IDLE, all outputs 0, pattern=1001, no done.
  - A following frame with 0x99 → match_cnt=2.
